// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with sequential / branch / jump / return
// next-address selection, a circular hardware return-address stack and a
// clock-enable stall.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned targets hold the PC
// and set the sticky align_err flag; undefined = no check, align_err = 0).
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic [1:0]                 sel,
    input  logic [WIDTH-1:0]           branch_off,
    input  logic [WIDTH-1:0]           jump_addr,
    input  logic                       ras_push,
    output logic [WIDTH-1:0]           pc,
    output logic [WIDTH-1:0]           pc_seq,
    output logic [WIDTH-1:0]           ras_top,
    output logic [$clog2(DEPTH+1)-1:0] ras_count,
    output logic                       ras_ovf,
    output logic                       ras_udf,
    output logic                       align_err
);

    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_MAX  = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    // Architectural state. sp_q points at the next free slot; the top entry
    // sits one below it (mod DEPTH). When full, sp_q points at the oldest
    // entry, so a push naturally overwrites it.
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
`ifdef PC_ALIGN_CHECK_EN
    logic             align_q, align_d;
`endif

    // Stack storage has no reset: entries beyond ras_count are don't-care.
    logic [WIDTH-1:0] ras_mem [DEPTH];

    logic [WIDTH-1:0] seq_addr;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] target;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    sp_inc;
    logic [PW-1:0]    wr_idx;
    logic             wr_en;
    logic             ras_empty;
    logic             do_pop;

    assign seq_addr  = pc_q + WIDTH'(STEP);
    assign ras_empty = (cnt_q == '0);
    assign top_idx   = (sp_q == '0) ? PTR_MAX : sp_q - 1'b1;
    assign sp_inc    = (sp_q == PTR_MAX) ? '0 : sp_q + 1'b1;
    assign top_val   = ras_empty ? '0 : ras_mem[top_idx];

    // Next-state: target selection, RAS push/pop bookkeeping, sticky flags.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
`ifdef PC_ALIGN_CHECK_EN
        align_d = align_q;
`endif
        target  = seq_addr;
        wr_en   = 1'b0;
        wr_idx  = sp_q;
        do_pop  = 1'b0;
        if (ce) begin
            case (sel)
                2'b00: target = seq_addr;
                2'b01: target = seq_addr + branch_off;
                2'b10: target = jump_addr;
                default: begin
                    if (!ras_empty) begin
                        target = top_val;
                        do_pop = 1'b1;
                    end else begin
                        target = seq_addr;
                        udf_d  = 1'b1;
                    end
                end
            endcase

`ifdef PC_ALIGN_CHECK_EN
            // A misaligned target is refused; the RAS still updates.
            if (target[1:0] != 2'b00) begin
                align_d = 1'b1;
            end else begin
                pc_d = target;
            end
`else
            pc_d = target;
`endif

            if (ras_push) begin
                wr_en = 1'b1;
                if (do_pop) begin
                    // Pop and push together: replace the top slot in place.
                    wr_idx = top_idx;
                end else begin
                    wr_idx = sp_q;
                    sp_d   = sp_inc;
                    if (cnt_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end else if (do_pop) begin
                sp_d  = top_idx;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            sp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_q <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`ifdef PC_ALIGN_CHECK_EN
            align_q <= align_d;
`endif
        end
    end

    // Link-address write into the stack storage (pre-update PC + STEP).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= seq_addr;
        end
    end

    assign pc        = pc_q;
    assign pc_seq    = seq_addr;
    assign ras_top   = top_val;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_udf   = udf_q;
`ifdef PC_ALIGN_CHECK_EN
    assign align_err = align_q;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the Lab3 CPU datapath. Supersedes the plain clock-enabled PC register.
- Holds the PC and computes the sequential next address.
- Selects between sequential, branch-relative, absolute-jump and return targets.
- Maintains a small hardware return-address stack (RAS) for call/return.
- Stalls under a clock enable.

Parameters:
WIDTH, 32, PC and address width in bits (>= 8)
DEPTH, 4, RAS entries (>= 1)
STEP, 4, sequential increment in bytes
RESET_VEC, 0, PC value loaded on reset (WIDTH bits)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
ce  input  1  advance enable; 0 = stall, all state held
sel  input  2  next-PC mode: 00 seq, 01 branch, 10 jump, 11 return
branch_off  input  WIDTH  signed byte offset for branch
jump_addr  input  WIDTH  absolute target for jump
ras_push  input  1  push link address (pc+STEP) onto RAS
pc  output  WIDTH  current PC (registered)
pc_seq  output  WIDTH  pc+STEP (combinational, mod 2^WIDTH)
ras_top  output  WIDTH  top RAS entry; 0 when empty
ras_count  output  $clog2(DEPTH+1)  valid entries in RAS
ras_ovf  output  1  sticky: push dropped oldest entry
ras_udf  output  1  sticky: return with empty RAS
align_err  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (async assert, any time, including mid-stall): pc=RESET_VEC, ras_count=0, ras_top=0, ras_ovf=0, ras_udf=0, align_err=0. RAS contents are don't-care.
- All updates occur on the rising clk edge with ce=1. With ce=0, pc, the RAS, count and flags all hold, and ras_push/sel are ignored.
- Next PC, all arithmetic mod 2^WIDTH:
  - sel=00: pc+STEP.
  - sel=01: pc+STEP+branch_off.
  - sel=10: jump_addr.
  - sel=11, ras_count>0: ras_top, and the entry is popped.
  - sel=11, ras_count=0: pc+STEP, and ras_udf is set. No pop.
- Latency: the new PC is visible on pc one cycle after the enabled edge. pc_seq and ras_top follow the registered state combinationally.
- Push (ras_push=1, ce=1): writes pc_seq (the pre-update PC+STEP) as the new top.
  - Count below DEPTH: ras_count increments.
  - Count equal to DEPTH: the oldest entry is overwritten (circular pointer), ras_count stays at DEPTH, and ras_ovf is set.
- Simultaneous push and return with non-empty RAS: the pop uses the old top for the PC, then the top slot is replaced by pc_seq. ras_count is unchanged and no flags change.
- Simultaneous push and return with empty RAS: the PC goes to pc+STEP, ras_udf is set, and the push then lands with ras_count=1.
- ras_ovf, ras_udf and align_err clear only on reset.
- Stack pointer wraps modulo DEPTH. Pop after an overflow returns the DEPTH most-recent links in LIFO order.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: on an enabled edge where the selected next PC has bits [1:0] != 0, pc holds its value and align_err is set.
  - RAS push/pop for that cycle still take effect.
  - ras_udf still sets if applicable.
- Undefined: no alignment check; misaligned targets load as-is and align_err is tied to 0.

Test Plan:
- Reset and sequential: reset, then 3 cycles with ce=1, sel=00 -> pc = 0x0, 0x4, 0x8, 0xC; pc_seq = 0x10; all flags 0.
- Stall and branch:
  - At pc=0x10, ce=0 for 2 cycles -> pc stays 0x10.
  - Then sel=01, branch_off=0xFFFFFFF0 -> pc=0x4.
  - Then sel=10, jump_addr=0x100 -> pc=0x100.
- Call/return: at pc=0x100, sel=10, jump_addr=0x200, ras_push=1 -> pc=0x200, ras_top=0x104, ras_count=1. Then sel=11 -> pc=0x104, ras_count=0, ras_top=0.
- Overflow/underflow (DEPTH=4):
  - 5 pushes at pc 0x0, 0x4, 0x8, 0xC, 0x10 -> ras_count=4, ras_ovf=1.
  - 4 returns -> PCs 0x14, 0x10, 0xC, 0x8, in that order.
  - 5th return -> pc = prev+4, ras_udf=1.
- Simultaneous push+return: RAS top 0x104, pc=0x300, sel=11, ras_push=1 -> pc=0x104, ras_top=0x304, ras_count unchanged.
- Async reset mid-operation, plus alignment:
  - Assert reset between edges with ras_count=3 -> pc=RESET_VEC immediately, ras_count=0.
  - With PC_ALIGN_CHECK_EN: sel=10, jump_addr=0x102 -> pc holds, align_err=1.
